// File: rtl/arb_mux_rr_if.sv
// Handshake bundle between N_IN producer channels and one registered consumer port.
// Latency: none (signal bundle only).
// Backpressure: carries in_ready per channel and out_ready from the consumer.
//
// master modport: the arbiter's view (drives in_ready and the out_* register outputs).
// slave  modport: the surrounding environment's view (drives in_valid, in_data, out_ready).
interface arb_mux_rr_if #(
    parameter int WIDTH = 4,
    parameter int N_IN  = 4
);
    localparam int SEL_W = $clog2(N_IN);

    logic [N_IN-1:0]       in_valid;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_ready;

    modport master (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );

    modport slave (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );
endinterface

// File: rtl/arb_mux_rr.sv
// N_IN-to-1 arbitrating mux (round-robin or fixed priority) into a single output register.
// Latency: 1 cycle from input handshake to out_valid; sustains one transfer per clock.
// Backpressure: in_ready is combinational and all-zero while the output register is full and not popped.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; clears output register and rotation pointer
//   rr_en  - 1: scan starts at the rotation pointer, 0: scan starts at channel 0
//   bus    - arb_mux_rr_if.master: in_valid/in_data/in_ready per channel,
//            out_valid/out_data/out_sel/out_ready on the consumer side
module arb_mux_rr #(
    parameter int WIDTH = 4,
    parameter int N_IN  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rr_en,
    arb_mux_rr_if.master  bus
);
    localparam int SEL_W = $clog2(N_IN);
    localparam int CW    = SEL_W + 1;

    logic [WIDTH-1:0] chan_data [N_IN];

    logic             load;
    logic             found;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] scan_start;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [N_IN-1:0]  grant_oh;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_sel_q;

    // Unpack the flat data bus so the selected channel can be indexed directly by grant.
    for (genvar i = 0; i < N_IN; i++) begin : g_unpack
        assign chan_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    // The register can take new data when empty or when its current contents leave this cycle.
    assign load = !out_valid_q || bus.out_ready;

    // First requesting channel at or above scan_start, wrapping modulo N_IN.
    // The sum is one bit wider than an index so the wrap can be detected for any N_IN.
    always_comb begin
        logic [CW-1:0]    sum;
        logic [SEL_W-1:0] sidx;
        found      = 1'b0;
        grant      = '0;
        sum        = '0;
        sidx       = '0;
        scan_start = rr_en ? ptr : '0;
        for (int k = 0; k < N_IN; k++) begin
            sum = {1'b0, scan_start} + CW'(k);
            if (sum >= CW'(N_IN)) begin
                sum = sum - CW'(N_IN);
            end
            sidx = sum[SEL_W-1:0];
            if (!found && bus.in_valid[sidx]) begin
                found = 1'b1;
                grant = sidx;
            end
        end
    end

    // Next rotation start is the channel just after the winner.
    assign ptr_nxt = (grant == SEL_W'(N_IN - 1)) ? '0 : grant + 1'b1;

    // in_ready is gated by rst_n so no channel sees an acceptance while reset is held.
    always_comb begin
        grant_oh = '0;
        if (rst_n && load && found) begin
            grant_oh[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr         <= '0;
        end else if (load) begin
            if (found) begin
                out_valid_q <= 1'b1;
                out_data_q  <= chan_data[grant];
                out_sel_q   <= grant;
                if (rr_en) begin
                    ptr <= ptr_nxt;
                end
            end else begin
                // Nothing to load: drop valid but keep the last data/sel visible.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = grant_oh;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule
